// File: rtl/led_panel_bcm_driver.sv
// HUB75 panel driver: double-buffered frame store scanned out with binary-coded modulation.
// A swap requested by the user side takes effect only at a frame boundary.
module led_panel_bcm_driver #(
  parameter int COLS       = 32,
  parameter int ROWS       = 16,
  parameter int DEPTH      = 4,
  parameter int BASE_TICKS = 8,
  localparam int RW        = (ROWS > 2) ? $clog2(ROWS) : 1,
  localparam int CW        = $clog2(COLS)
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               WR_EN,
  input  logic [RW-1:0]      WR_ROW,
  input  logic [CW-1:0]      WR_COL,
  input  logic [3*DEPTH-1:0] WR_DATA,
  input  logic               SWAP_REQ,
  output logic               SWAP_DONE,
  output logic               LP_CLOCK,
  output logic               LP_LATCH,
  output logic               LP_BLANK,
  output logic [2:0]         LP_RGB_0,
  output logic [2:0]         LP_RGB_1,
  output logic [4:0]         LP_ADDRESS
);

  localparam int HALF = ROWS / 2;
  localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NPIX = ROWS * COLS;
  localparam int MW   = $clog2(2 * NPIX);
  localparam int MAXT = BASE_TICKS << (DEPTH - 1);
  localparam int TW   = $clog2(MAXT + 1);
  localparam int PXW  = 3 * DEPTH;

  typedef enum logic [2:0] {
    S_FETCH, S_LOAD, S_CLK_HI, S_CLK_LO, S_LATCH_HI, S_LATCH_LO, S_SHOW
  } state_t;

  state_t          state_q;
  logic [AW-1:0]   addr_q;
  logic [PW-1:0]   plane_q;
  logic [CW-1:0]   col_q;
  logic [TW-1:0]   tick_q;
  logic            disp_sel_q;
  logic            swap_pend_q;
  logic            swap_done_q;
  logic            lp_clock_q, lp_latch_q, lp_blank_q;
  logic [2:0]      lp_rgb0_q, lp_rgb1_q;
  logic [4:0]      lp_addr_q;

  // Both frame buffers live in one array; the top index bit selects the buffer.
  logic [PXW-1:0]  mem_q [0:2*NPIX-1];
  logic [PXW-1:0]  rd0_q, rd1_q;
  logic [MW-1:0]   wr_idx, rd0_idx, rd1_idx;
  logic            wr_ok;
  logic [TW-1:0]   show_len;

  always_comb begin
    wr_idx  = MW'({31'b0, ~disp_sel_q} * NPIX + 32'(WR_ROW) * COLS + 32'(WR_COL));
    rd0_idx = MW'({31'b0, disp_sel_q} * NPIX + 32'(addr_q) * COLS + 32'(col_q));
    rd1_idx = MW'({31'b0, disp_sel_q} * NPIX + (32'(addr_q) + HALF) * COLS + 32'(col_q));
    wr_ok   = WR_EN && ({1'b0, WR_ROW} < (RW + 1)'(ROWS)) && ({1'b0, WR_COL} < (CW + 1)'(COLS));
  end

  assign show_len = TW'(BASE_TICKS) << plane_q;

  function automatic logic [2:0] plane_bits(input logic [PXW-1:0] px, input logic [PW-1:0] pl);
    logic [2:0] r;
    r = 3'b000;
    for (int b = 0; b < DEPTH; b++)
      if (PW'(b) == pl) r = {px[b], px[DEPTH + b], px[2 * DEPTH + b]};
    return r;
  endfunction

  always_ff @(posedge CLOCK) begin
    if (wr_ok) mem_q[wr_idx] <= WR_DATA;
    rd0_q <= mem_q[rd0_idx];
    rd1_q <= mem_q[rd1_idx];
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q     <= S_FETCH;
      addr_q      <= '0;
      plane_q     <= '0;
      col_q       <= CW'(COLS - 1);
      tick_q      <= '0;
      disp_sel_q  <= 1'b0;
      swap_pend_q <= 1'b0;
      swap_done_q <= 1'b0;
      lp_clock_q  <= 1'b0;
      lp_latch_q  <= 1'b0;
      lp_blank_q  <= 1'b1;
      lp_rgb0_q   <= 3'b000;
      lp_rgb1_q   <= 3'b000;
      lp_addr_q   <= 5'd0;
    end else begin
      swap_done_q <= 1'b0;
      if (SWAP_REQ) swap_pend_q <= 1'b1;
      case (state_q)
        S_FETCH: state_q <= S_LOAD;
        S_LOAD: begin
          lp_rgb0_q <= plane_bits(rd0_q, plane_q);
          lp_rgb1_q <= plane_bits(rd1_q, plane_q);
          state_q   <= S_CLK_HI;
        end
        S_CLK_HI: begin
          lp_clock_q <= 1'b1;
          state_q    <= S_CLK_LO;
        end
        S_CLK_LO: begin
          lp_clock_q <= 1'b0;
          if (col_q != '0) begin
            col_q   <= col_q - CW'(1);
            state_q <= S_FETCH;
          end else begin
            state_q <= S_LATCH_HI;
          end
        end
        S_LATCH_HI: begin
          lp_latch_q <= 1'b1;
          lp_addr_q  <= 5'(addr_q);
          state_q    <= S_LATCH_LO;
        end
        S_LATCH_LO: begin
          lp_latch_q <= 1'b0;
          lp_blank_q <= 1'b0;
          tick_q     <= '0;
          state_q    <= S_SHOW;
        end
        S_SHOW: begin
          if (tick_q == show_len - TW'(1)) begin
            lp_blank_q <= 1'b1;
            col_q      <= CW'(COLS - 1);
            state_q    <= S_FETCH;
            if (plane_q == PW'(DEPTH - 1)) begin
              plane_q <= '0;
              if (addr_q == AW'(HALF - 1)) begin
                addr_q <= '0;
                // A request arriving in this very cycle still counts for this frame end.
                if (swap_pend_q || SWAP_REQ) begin
                  disp_sel_q  <= ~disp_sel_q;
                  swap_pend_q <= 1'b0;
                  swap_done_q <= 1'b1;
                end
              end else begin
                addr_q <= addr_q + AW'(1);
              end
            end else begin
              plane_q <= plane_q + PW'(1);
            end
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign SWAP_DONE  = swap_done_q;
  assign LP_CLOCK   = lp_clock_q;
  assign LP_LATCH   = lp_latch_q;
  assign LP_BLANK   = lp_blank_q;
  assign LP_RGB_0   = lp_rgb0_q;
  assign LP_RGB_1   = lp_rgb1_q;
  assign LP_ADDRESS = lp_addr_q;

endmodule

// File: tb/tb_led_panel_bcm_driver.sv
// Bench for led_panel_bcm_driver on a 4x4 panel, 2-bit colour, 2 base ticks.
module tb_led_panel_bcm_driver;
  localparam int COLS = 4, ROWS = 4, DEPTH = 2, BT = 2, HALF = ROWS / 2;

  function automatic int line_len(input int l);
    return 4 * COLS + 2 + (BT << (l % DEPTH));
  endfunction
  function automatic int frame_len(input int nlines);
    int t = 0;
    for (int l = 0; l < nlines; l++) t += line_len(l);
    return t;
  endfunction
  localparam int FRAME = frame_len(HALF * DEPTH);

  logic       CLOCK = 1'b0, RESET = 1'b1, WR_EN = 1'b0, SWAP_REQ = 1'b0;
  logic [1:0] WR_ROW = '0, WR_COL = '0;
  logic [5:0] WR_DATA = '0;
  logic       SWAP_DONE, LP_CLOCK, LP_LATCH, LP_BLANK;
  logic [2:0] LP_RGB_0, LP_RGB_1;
  logic [4:0] LP_ADDRESS;

  led_panel_bcm_driver #(.COLS(COLS), .ROWS(ROWS), .DEPTH(DEPTH), .BASE_TICKS(BT)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .WR_EN(WR_EN), .WR_ROW(WR_ROW), .WR_COL(WR_COL),
    .WR_DATA(WR_DATA), .SWAP_REQ(SWAP_REQ), .SWAP_DONE(SWAP_DONE), .LP_CLOCK(LP_CLOCK),
    .LP_LATCH(LP_LATCH), .LP_BLANK(LP_BLANK), .LP_RGB_0(LP_RGB_0), .LP_RGB_1(LP_RGB_1),
    .LP_ADDRESS(LP_ADDRESS));

  always #5 CLOCK = ~CLOCK;

  int n_cmp = 0, n_bad = 0;
  bit chk_en = 1'b0;

  // Reference model: cycle index since reset, buffer contents, swap bookkeeping.
  int         cyc = 0;
  logic       m_sel = 1'b0, m_pend = 1'b0, exp_done = 1'b0;
  logic [5:0] mbuf [2][ROWS][COLS];

  always @(posedge CLOCK) begin
    if (RESET) begin
      cyc      <= 0;
      m_sel    <= 1'b0;
      m_pend   <= 1'b0;
      exp_done <= 1'b0;
    end else begin
      cyc      <= cyc + 1;
      exp_done <= 1'b0;
      if (WR_EN) mbuf[!m_sel][WR_ROW][WR_COL] <= WR_DATA;
      if ((cyc % FRAME) == FRAME - 1 && (m_pend || SWAP_REQ)) begin
        m_sel    <= !m_sel;
        m_pend   <= 1'b0;
        exp_done <= 1'b1;
      end else if (SWAP_REQ) begin
        m_pend <= 1'b1;
      end
    end
  end

  // Expected {B,G,R} pin value for one pixel in bit plane p, by channel arithmetic.
  function automatic int plane_bits(input logic [5:0] px, input int p);
    int v, r, g, b;
    v = int'(px);
    r = ((v >> (2 * DEPTH)) >> p) & 1;
    g = ((v >> DEPTH) >> p) & 1;
    b = (v >> p) & 1;
    return b * 4 + g * 2 + r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_rst();
    check("rst_blank", int'(LP_BLANK), 1);
    check("rst_clock", int'(LP_CLOCK), 0);
    check("rst_latch", int'(LP_LATCH), 0);
    check("rst_rgb0", int'(LP_RGB_0), 0);
    check("rst_rgb1", int'(LP_RGB_1), 0);
    check("rst_addr", int'(LP_ADDRESS), 0);
    check("rst_swap_done", int'(SWAP_DONE), 0);
  endtask

  task automatic wait_mod(input int target, input int modulus);
    int guard = 0;
    while ((cyc % modulus) != target && guard < 4 * FRAME) begin
      @(negedge CLOCK);
      guard++;
    end
    if (guard >= 4 * FRAME) check("wait_timeout", 0, 1);
  endtask

  task automatic write_px(input int r, input int c, input int d);
    WR_EN = 1'b1; WR_ROW = 2'(r); WR_COL = 2'(c); WR_DATA = 6'(d);
    @(negedge CLOCK);
    WR_EN = 1'b0;
  endtask

  task automatic swap_and_wait();
    int guard = 0;
    SWAP_REQ = 1'b1;
    @(negedge CLOCK);
    SWAP_REQ = 1'b0;
    while (!SWAP_DONE && guard < 3 * FRAME) begin
      @(negedge CLOCK);
      guard++;
    end
    if (guard >= 3 * FRAME) check("swap_timeout", 0, 1);
  endtask

  // Line monitor: collects shifted pixels, checks each latched line and each on-time.
  initial begin : monitor
    int nclk, run, last_plane, off, s, l, p, a;
    logic pc, pl;
    logic [2:0] sh0 [COLS];
    logic [2:0] sh1 [COLS];
    nclk = 0; run = 0; last_plane = 0; pc = 1'b0; pl = 1'b0;
    forever begin
      @(negedge CLOCK);
      if (RESET) begin
        nclk = 0; run = 0; pc = 1'b0; pl = 1'b0;
      end else begin
        check("swap_done", int'(SWAP_DONE), int'(exp_done));
        if (chk_en) begin
          if (LP_CLOCK && !pc) begin
            check("blank_during_shift", int'(LP_BLANK), 1);
            if (nclk < COLS) begin
              sh0[nclk] = LP_RGB_0;
              sh1[nclk] = LP_RGB_1;
            end
            nclk++;
          end
          if (LP_LATCH && !pl) begin
            off = cyc % FRAME; l = 0; s = 0;
            while (s + line_len(l) <= off) begin
              s += line_len(l);
              l++;
            end
            p = l % DEPTH;
            a = l / DEPTH;
            check("latch_pos", off - s, 4 * COLS + 1);
            check("latch_addr", int'(LP_ADDRESS), a);
            check("shift_count", nclk, COLS);
            for (int k = 0; k < COLS && k < nclk; k++) begin
              check("rgb0", int'(sh0[k]), plane_bits(mbuf[m_sel][a][COLS-1-k], p));
              check("rgb1", int'(sh1[k]), plane_bits(mbuf[m_sel][a+HALF][COLS-1-k], p));
            end
            last_plane = p;
            nclk = 0;
          end
          if (!LP_BLANK) run++;
          else if (run > 0) begin
            check("on_time", run, BT << last_plane);
            run = 0;
          end
        end
        pc = LP_CLOCK;
        pl = LP_LATCH;
      end
    end
  end

  typedef struct {
    int         cyc;
    logic       blank;
    logic       clk;
    logic       lat;
    logic [4:0] addr;
  } vec_t;

  initial begin : main
    vec_t tbl [18];
    int   cnt, guard;
    // Pin timeline after reset release: plane periods 20/22, frame 84.
    tbl[0]  = '{0,   1'b1, 1'b0, 1'b0, 5'd0};
    tbl[1]  = '{3,   1'b1, 1'b1, 1'b0, 5'd0};
    tbl[2]  = '{4,   1'b1, 1'b0, 1'b0, 5'd0};
    tbl[3]  = '{15,  1'b1, 1'b1, 1'b0, 5'd0};
    tbl[4]  = '{16,  1'b1, 1'b0, 1'b0, 5'd0};
    tbl[5]  = '{17,  1'b1, 1'b0, 1'b1, 5'd0};
    tbl[6]  = '{18,  1'b0, 1'b0, 1'b0, 5'd0};
    tbl[7]  = '{19,  1'b0, 1'b0, 1'b0, 5'd0};
    tbl[8]  = '{20,  1'b1, 1'b0, 1'b0, 5'd0};
    tbl[9]  = '{37,  1'b1, 1'b0, 1'b1, 5'd0};
    tbl[10] = '{38,  1'b0, 1'b0, 1'b0, 5'd0};
    tbl[11] = '{41,  1'b0, 1'b0, 1'b0, 5'd0};
    tbl[12] = '{42,  1'b1, 1'b0, 1'b0, 5'd0};
    tbl[13] = '{59,  1'b1, 1'b0, 1'b1, 5'd1};
    tbl[14] = '{60,  1'b0, 1'b0, 1'b0, 5'd1};
    tbl[15] = '{62,  1'b1, 1'b0, 1'b0, 5'd1};
    tbl[16] = '{83,  1'b0, 1'b0, 1'b0, 5'd1};
    tbl[17] = '{101, 1'b1, 1'b0, 1'b1, 5'd0};

    RESET = 1'b1;
    repeat (3) @(negedge CLOCK);
    check_rst();
    RESET = 1'b0;

    // Fill back buffer 1, show it, then fill buffer 0 with the directed pixels.
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) write_px(r, c, int'($urandom_range(0, 63)));
    swap_and_wait();
    chk_en = 1'b1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) write_px(r, c, int'($urandom_range(0, 63)));
    write_px(0, 3, 6'b10_00_00);
    write_px(HALF, 0, 6'b11_11_11);
    swap_and_wait();
    repeat (FRAME + 5) @(negedge CLOCK);

    // Reset held three cycles in the middle of an on-time.
    guard = 0;
    while (LP_BLANK && guard < FRAME) begin
      @(negedge CLOCK);
      guard++;
    end
    check("reach_show", int'(LP_BLANK), 0);
    RESET = 1'b1;
    repeat (3) begin
      @(negedge CLOCK);
      check_rst();
    end
    RESET = 1'b0;

    for (int i = 0; i < 18; i++) begin
      wait_mod(tbl[i].cyc, 1000000);
      check("tbl_blank", int'(LP_BLANK), int'(tbl[i].blank));
      check("tbl_clock", int'(LP_CLOCK), int'(tbl[i].clk));
      check("tbl_latch", int'(LP_LATCH), int'(tbl[i].lat));
      check("tbl_addr", int'(LP_ADDRESS), int'(tbl[i].addr));
    end

    // Request raised on the frame-end cycle itself.
    wait_mod(FRAME - 1, FRAME);
    SWAP_REQ = 1'b1;
    @(negedge CLOCK);
    SWAP_REQ = 1'b0;
    check("swap_at_frame_end", int'(SWAP_DONE), 1);

    // Two requests inside one frame merge into one swap.
    wait_mod(5, FRAME);
    SWAP_REQ = 1'b1;
    @(negedge CLOCK);
    SWAP_REQ = 1'b0;
    repeat (10) @(negedge CLOCK);
    SWAP_REQ = 1'b1;
    @(negedge CLOCK);
    SWAP_REQ = 1'b0;
    cnt = 0;
    repeat (2 * FRAME) begin
      @(negedge CLOCK);
      if (SWAP_DONE) cnt++;
    end
    check("merged_swaps", cnt, 1);

    // Random writes and swap requests against the model.
    repeat (3000) begin
      WR_EN    = 1'($urandom_range(0, 1));
      WR_ROW   = 2'($urandom_range(0, ROWS - 1));
      WR_COL   = 2'($urandom_range(0, COLS - 1));
      WR_DATA  = 6'($urandom_range(0, 63));
      SWAP_REQ = ($urandom_range(0, 59) == 0);
      @(negedge CLOCK);
    end
    WR_EN = 1'b0;
    SWAP_REQ = 1'b0;
    repeat (2 * FRAME) @(negedge CLOCK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
